pixel_packetizer: RTL
=====================

# pixel_packetizer

Ingress stage between the host byte stream and the processor's NoC injection port. Accepts one pixel byte per handshake from the PCIe side, tags it with a destination PE coordinate (round-robin over all mesh nodes except node (0,0), which hosts the host interface) and a frame-relative pixel index, and emits one NoC packet per pixel. A two-entry skid buffer registers the upstream ready so this stage does not lengthen the NoC's ready path. Stops accepting after a full frame until re-armed.

## Interface
- X, 2: mesh columns.
- Y, 2: mesh rows; X*Y ≥ 2.
- data_width, 8: pixel width.
- x_size, 1: bits of x coordinate; 2**x_size ≥ X.
- y_size, 1: bits of y coordinate; 2**y_size ≥ Y.
- id_width, 18: pixel index width.
- PIXELS, 262144: pixels per frame; 1 ≤ PIXELS ≤ 2**id_width.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid_pci  in  1  pixel byte valid.
- i_data_pci  in  data_width  pixel byte.
- o_ready_pci  out  1  stage can accept a pixel; registered.
- o_valid  out  1  packet valid toward NoC injection.
- o_data  out  id_width+y_size+x_size+data_width  packet {pixel_id, dest_y, dest_x, pixel}, pixel in LSBs.
- i_ready  in  1  NoC injection port accepts packet.
- i_restart  in  1  single-cycle pulse; re-arms for next frame.
- o_done  out  1  all PIXELS accepted and drained.

## Operation
- Input handshake: pixel accepted when i_valid_pci & o_ready_pci. Output handshake: packet consumed when o_valid & i_ready.
- On each accepted pixel: tag with current (dest_x, dest_y, pixel_id), write to skid buffer, then advance counters.
- Destination sequence: row-major, x fastest: (1,0),(0,1),(1,1),(0,0)?—no; (0,0) skipped always. Sequence for X=2,Y=2: (1,0),(0,1),(1,1),(1,0),... Wrap from (X-1,Y-1) to (1,0).
- pixel_id: 0 at frame start, +1 per accepted pixel; last value PIXELS-1.
- Skid buffer: 2 entries, FIFO order. o_valid = not empty; o_data = head entry.
- o_ready_pci (registered) = 1 next cycle iff, after this cycle's push/pop, occupancy ≤ 0 plus one slot guaranteed: i.e. next occupancy < 2 and frame not complete. A push may occur in the cycle o_ready_pci is high even if buffer reaches 2 that cycle; ready drops next cycle. Occupancy never exceeds 2.
- Frame complete: after the accept with pixel_id = PIXELS-1, accepted-count flag set; o_ready_pci low from next cycle. i_valid_pci while ready low ignored.
- o_done = frame complete & buffer empty; held until i_restart or rst.
- i_restart: effective only when o_done=1; clears flag, resets pixel_id to 0 and destination to (1,0), o_ready_pci high next cycle. Ignored otherwise.
- Simultaneous push and pop: both happen; occupancy unchanged.

## Timing
- Reset values: o_ready_pci=0, o_valid=0, o_data=0, o_done=0; counters cleared; o_ready_pci rises first cycle after rst deasserts.
- Latency: pixel accepted in cycle N appears on o_valid/o_data in cycle N+1 if buffer was empty.
- Throughput: 1 pixel/cycle sustained when i_ready held high.
- o_data stable while o_valid & !i_ready (no change until consumed).
- rst mid-frame: buffer flushed, in-flight pixels dropped, counters to start; no partial output.

## Structure
- Shared package/include: packet field widths and offsets (pixel LSB, dest_x, dest_y, pixel_id MSB), derived packet width, reserved host node coordinate (0,0).
- One sub-module natural: skid_buffer2 (2-entry registered-ready FIFO, width parameter); destination/ID counters live in the top.

## Test plan
- Reset then stream 8 pixels 0x10..0x17, i_ready=1 (X=Y=2) -> packets in order with dest (1,0),(0,1),(1,1),(1,0),(0,1),(1,1),(1,0),(0,1), pixel_id 0..7, one per cycle, 1-cycle latency.
- i_ready=0 while streaming -> exactly 2 pixels accepted, o_ready_pci low the cycle after second; o_data holds first packet; releasing i_ready drains both in order with no loss/duplicate.
- PIXELS=4, stream 6 pixels -> only 4 accepted, o_ready_pci low afterward, o_done=1 after last packet consumed; i_restart -> next pixel has pixel_id 0, dest (1,0).
- i_restart pulse while mid-frame (pixel_id 2) -> ignored; counters continue at 3.
- rst asserted with 2 packets buffered -> o_valid=0 next cycle, stream restarts at pixel_id 0, dest (1,0).
- Random i_valid_pci/i_ready toggling, 1000 pixels, PIXELS=1000 -> scoreboard matches data, ids 0..999, dest sequence, o_done at end.

Source files
------------

// File: rtl/pixel_packetizer_pkg.sv
// Shared packet layout and mesh constants for the pixel ingress stage.
package pixel_packetizer_pkg;

    localparam int DATA_W = 8;
    localparam int X_SIZE = 1;
    localparam int Y_SIZE = 1;
    localparam int ID_W   = 18;

    // Node (0,0) hosts the host interface and never receives pixels.
    localparam int HOST_X = 0;
    localparam int HOST_Y = 0;

    localparam int PIX_LSB = 0;

    function automatic int pkt_width(int id_w, int y_s, int x_s, int d_w);
        return id_w + y_s + x_s + d_w;
    endfunction

    function automatic int dest_x_lsb(int d_w);
        return PIX_LSB + d_w;
    endfunction

    function automatic int dest_y_lsb(int d_w, int x_s);
        return PIX_LSB + d_w + x_s;
    endfunction

    function automatic int pixel_id_msb(int id_w, int y_s, int x_s, int d_w);
        return pkt_width(id_w, y_s, x_s, d_w) - 1;
    endfunction

endpackage

// File: rtl/pixel_packetizer_skid.sv
// Two-entry FIFO whose upstream ready is a flop, so the
// downstream ready never reaches the upstream port combinationally.
module skid_buffer2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         stop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic         ready_o
);

    logic [W-1:0] mem_q [2];
    logic [1:0]   cnt_q, cnt_d;
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    logic         ready_q, ready_d;
    logic         do_push, do_pop;

    always_comb begin
        do_push = push_i && (cnt_q != 2'd2);
        do_pop  = pop_i && (cnt_q != 2'd0);
        rd_d    = rd_q ^ do_pop;
        wr_d    = wr_q ^ do_push;
        cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        // Only re-offer a slot that is certain to be free next cycle.
        ready_d = (cnt_d != 2'd2) && !stop_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            cnt_q    <= 2'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
            end
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ready_q <= ready_d;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != 2'd0);
    assign ready_o = ready_q;

endmodule

// File: rtl/pixel_packetizer.sv
// Tags host pixel bytes with a round-robin PE destination and a
// frame-relative index, and injects one NoC packet per pixel.
module pixel_packetizer
    import pixel_packetizer_pkg::*;
#(
    parameter int X          = 2,
    parameter int Y          = 2,
    parameter int data_width = DATA_W,
    parameter int x_size     = X_SIZE,
    parameter int y_size     = Y_SIZE,
    parameter int id_width   = ID_W,
    parameter int PIXELS     = 262144
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid_pci,
    input  logic [data_width-1:0] i_data_pci,
    output logic                  o_ready_pci,
    output logic                  o_valid,
    output logic [pkt_width(id_width, y_size, x_size, data_width)-1:0] o_data,
    input  logic                  i_ready,
    input  logic                  i_restart,
    output logic                  o_done
);

    localparam int PW    = pkt_width(id_width, y_size, x_size, data_width);
    localparam int START = HOST_Y * X + HOST_X + 1;

    localparam logic [x_size-1:0]   SX   = x_size'(START % X);
    localparam logic [y_size-1:0]   SY   = y_size'(START / X);
    localparam logic [x_size-1:0]   XL   = x_size'(X - 1);
    localparam logic [y_size-1:0]   YL   = y_size'(Y - 1);
    localparam logic [id_width-1:0] LAST = id_width'(PIXELS - 1);

    logic [x_size-1:0]   dx_q, dx_d;
    logic [y_size-1:0]   dy_q, dy_d;
    logic [id_width-1:0] id_q, id_d;
    logic                complete_q, complete_d;
    logic                accept, pop, rearm;
    logic [PW-1:0]       pkt;

    assign accept = i_valid_pci && o_ready_pci;
    assign pop    = o_valid && i_ready;
    assign rearm  = i_restart && o_done;
    assign pkt    = {id_q, dy_q, dx_q, i_data_pci};

    always_comb begin
        dx_d       = dx_q;
        dy_d       = dy_q;
        id_d       = id_q;
        complete_d = complete_q;
        if (accept) begin
            id_d = id_q + id_width'(1);
            if (id_q == LAST) begin
                complete_d = 1'b1;
            end
            // Row-major walk; wrapping lands past the host node.
            if (dx_q == XL) begin
                if (dy_q == YL) begin
                    dx_d = SX;
                    dy_d = SY;
                end else begin
                    dx_d = '0;
                    dy_d = dy_q + y_size'(1);
                end
            end else begin
                dx_d = dx_q + x_size'(1);
            end
        end
        if (rearm) begin
            complete_d = 1'b0;
            id_d       = '0;
            dx_d       = SX;
            dy_d       = SY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q       <= SX;
            dy_q       <= SY;
            id_q       <= '0;
            complete_q <= 1'b0;
        end else begin
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            id_q       <= id_d;
            complete_q <= complete_d;
        end
    end

    skid_buffer2 #(
        .W(PW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (pop),
        .stop_i  (complete_d),
        .din_i   (pkt),
        .dout_o  (o_data),
        .valid_o (o_valid),
        .ready_o (o_ready_pci)
    );

    assign o_done = complete_q && !o_valid;

endmodule
